// File: rtl/if_id_buffer_if.sv
// Bundles the fetch-side, decode-side and flush signals of the IF/ID buffer.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface if_id_buffer_if #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush_in;
    logic            fetch_valid_in;
    logic [XLEN-1:0] fetch_ins_in;
    logic [XLEN-1:0] fetch_pc_in;
    logic            fetch_ready_out;
    logic            dec_ready_in;
    logic            dec_valid_out;
    logic [XLEN-1:0] dec_pc_out;
    logic [4:0]      opcode_out;
    logic [2:0]      funct3_out;
    logic [6:0]      funct7_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;
    logic [4:0]      rd_out;
    logic            illegal_out;
    logic [CW-1:0]   count_out;

    // Environment side: drives fetch/decode requests, observes the buffer.
    modport master (
        output flush_in, fetch_valid_in, fetch_ins_in, fetch_pc_in, dec_ready_in,
        input  fetch_ready_out, dec_valid_out, dec_pc_out, opcode_out, funct3_out,
               funct7_out, rs1_out, rs2_out, rd_out, illegal_out, count_out
    );

    // Buffer side.
    modport slave (
        input  flush_in, fetch_valid_in, fetch_ins_in, fetch_pc_in, dec_ready_in,
        output fetch_ready_out, dec_valid_out, dec_pc_out, opcode_out, funct3_out,
               funct7_out, rs1_out, rs2_out, rd_out, illegal_out, count_out
    );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a DEPTH-entry FIFO of (instruction, PC) pairs whose head is
// split into RISC-V register/opcode fields for the decode stage.
module if_id_buffer #(
    parameter int DEPTH = 2,   // power of two, at least 2
    parameter int XLEN  = 32
) (
    input logic           clock_in,
    input logic           reset_in,
    if_id_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [XLEN-1:0] ins_mem [DEPTH];
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            not_full;
    logic            not_empty;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] head_ins;
    logic [XLEN-1:0] head_pc;

    // Ready/valid come only from the registered count, so dec_ready_in never reaches fetch_ready_out.
    assign not_full  = (count < FULL_COUNT);
    assign not_empty = (count != '0);
    assign push      = bus.fetch_valid_in && not_full;
    assign pop       = bus.dec_ready_in && not_empty;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; empty-state outputs are forced to zero below.
    always_ff @(posedge clock_in) begin
        if (push && !reset_in && !bus.flush_in) begin
            ins_mem[wr_ptr] <= bus.fetch_ins_in;
            pc_mem[wr_ptr]  <= bus.fetch_pc_in;
        end
    end

    assign head_ins = not_empty ? ins_mem[rd_ptr] : '0;
    assign head_pc  = not_empty ? pc_mem[rd_ptr]  : '0;

    assign bus.fetch_ready_out = not_full;
    assign bus.dec_valid_out   = not_empty;
    assign bus.count_out       = count;
    assign bus.dec_pc_out      = head_pc;
    assign bus.opcode_out      = head_ins[6:2];
    assign bus.funct3_out      = head_ins[14:12];
    assign bus.funct7_out      = head_ins[31:25];
    assign bus.rs1_out         = head_ins[19:15];
    assign bus.rs2_out         = head_ins[24:20];
    assign bus.rd_out          = head_ins[11:7];
    assign bus.illegal_out     = not_empty && (head_ins[1:0] != 2'b11);
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: a negedge monitor keeps a queue of accepted entries
// and checks every presented head, plus hand-computed spot checks from the main sequence.
module tb_if_id_buffer;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;
    logic mon_en;
    int   n_vec;
    int   n_err;

    logic [2*XLEN-1:0] exp_q[$];  // {pc, ins} in push order

    if_id_buffer_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    if_id_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: inputs change 1 time unit after the rising edge
    task automatic drive(input logic fv, input logic [XLEN-1:0] ins, input logic [XLEN-1:0] pc,
                         input logic dr, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        bus.fetch_valid_in = fv;
        bus.fetch_ins_in   = ins;
        bus.fetch_pc_in    = pc;
        bus.dec_ready_in   = dr;
        bus.flush_in       = fl;
        rst                = rs;
    endtask

    task automatic idle(input logic dr);
        drive(1'b0, '0, '0, dr, 1'b0, 1'b0);
    endtask

    // scoreboard monitor: compare state against the model, then apply the coming edge to it
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            logic [XLEN-1:0] e_ins;
            logic [XLEN-1:0] e_pc;
            logic will_push;
            sz = exp_q.size();
            e_ins = '0;
            e_pc  = '0;
            if (sz != 0) begin
                e_ins = exp_q[0][XLEN-1:0];
                e_pc  = exp_q[0][2*XLEN-1:XLEN];
            end
            check("count_out", 64'(bus.count_out), 64'(sz));
            check("dec_valid_out", 64'(bus.dec_valid_out), 64'(sz != 0));
            check("fetch_ready_out", 64'(bus.fetch_ready_out), 64'(sz < DEPTH));
            check("dec_pc_out", 64'(bus.dec_pc_out), 64'(e_pc));
            check("fields", {bus.opcode_out, bus.funct3_out, bus.funct7_out, bus.rs1_out,
                             bus.rs2_out, bus.rd_out},
                  {e_ins[6:2], e_ins[14:12], e_ins[31:25], e_ins[19:15], e_ins[24:20], e_ins[11:7]});
            check("illegal_out", 64'(bus.illegal_out), 64'((sz != 0) && (e_ins[1:0] != 2'b11)));
            will_push = bus.fetch_valid_in && (sz < DEPTH);
            if (rst || bus.flush_in) begin
                exp_q.delete();
            end else begin
                if (bus.dec_ready_in && sz != 0) begin
                    void'(exp_q.pop_front());
                end
                if (will_push) begin
                    exp_q.push_back({bus.fetch_pc_in, bus.fetch_ins_in});
                end
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.fetch_valid_in = 1'b0;
        bus.fetch_ins_in   = '0;
        bus.fetch_pc_in    = '0;
        bus.dec_ready_in   = 1'b0;
        bus.flush_in       = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);   // reset held with decode ready: must be ignored
        idle(1'b0);
        @(negedge clk);
        check("reset_ready", 64'(bus.fetch_ready_out), 64'd1);
        check("reset_valid", 64'(bus.dec_valid_out), 64'd0);
        check("reset_count", 64'(bus.count_out), 64'd0);
        check("reset_pc", 64'(bus.dec_pc_out), 64'd0);

        // single push of addi x5,x5,10, held at decode
        drive(1'b1, 32'h00A28293, 32'h100, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("r36_valid", 64'(bus.dec_valid_out), 64'd1);
        check("r36_opcode", 64'(bus.opcode_out), 64'h04);
        check("r36_rd", 64'(bus.rd_out), 64'd5);
        check("r36_rs1", 64'(bus.rs1_out), 64'd5);
        check("r36_rs2", 64'(bus.rs2_out), 64'd10);
        check("r36_funct3", 64'(bus.funct3_out), 64'd0);
        check("r36_funct7", 64'(bus.funct7_out), 64'd0);
        check("r36_pc", 64'(bus.dec_pc_out), 64'h100);
        check("r36_count", 64'(bus.count_out), 64'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);

        // fill to full, third instruction held upstream, then drain in order
        drive(1'b1, 32'h00100093, 32'h100, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00200113, 32'h104, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00300193, 32'h108, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("full_ready", 64'(bus.fetch_ready_out), 64'd0);
        check("full_count", 64'(bus.count_out), 64'd2);
        drive(1'b1, 32'h00300193, 32'h108, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0, 1'b0);  // pop while full: push ignored
        drive(1'b1, 32'h00300193, 32'h108, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("full_pop_count", 64'(bus.count_out), 64'd1);
        check("full_pop_pc", 64'(bus.dec_pc_out), 64'h104);
        idle(1'b1);
        @(negedge clk);
        check("held_pc", 64'(bus.dec_pc_out), 64'h108);
        idle(1'b1);
        idle(1'b0);

        // streaming: 10 pushes with decode always ready
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h00000013 | (32'(i) << 7), 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            if (i > 0) begin
                @(negedge clk);
                check("stream_count", 64'(bus.count_out), 64'd1);
                check("stream_pc", 64'(bus.dec_pc_out), 64'h200 + 64'(4 * (i - 1)));
            end
        end
        idle(1'b1);
        @(negedge clk);
        check("stream_last_pc", 64'(bus.dec_pc_out), 64'h224);
        idle(1'b0);

        // flush while full with a push in the same cycle
        drive(1'b1, 32'h00400213, 32'h400, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00500293, 32'h404, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00600313, 32'h408, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("flush_count", 64'(bus.count_out), 64'd0);
        check("flush_valid", 64'(bus.dec_valid_out), 64'd0);
        idle(1'b0);
        @(negedge clk);
        check("flush_lost", 64'(bus.count_out), 64'd0);

        // illegal encoding detection, then reset with an entry buffered
        drive(1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00000000, 32'h304, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        @(negedge clk);
        check("legal_head", 64'(bus.illegal_out), 64'd0);
        idle(1'b0);
        @(negedge clk);
        check("illegal_head", 64'(bus.illegal_out), 64'd1);
        check("illegal_count", 64'(bus.count_out), 64'd1);
        drive(1'b1, 32'h00700393, 32'h500, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        check("rst_count", 64'(bus.count_out), 64'd0);
        check("rst_valid", 64'(bus.dec_valid_out), 64'd0);
        check("rst_ready", 64'(bus.fetch_ready_out), 64'd1);
        check("rst_illegal", 64'(bus.illegal_out), 64'd0);
        check("rst_pc", 64'(bus.dec_pc_out), 64'd0);
        idle(1'b0);
        idle(1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: IF_ID_BUFFER

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 2: number of buffered instruction entries, power of two, minimum 2.
REQ-002 The block SHALL have a parameter XLEN, default 32: width of PC and instruction words.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clock_in  input  1  rising-edge clock.
REQ-004 reset_in  input  1  synchronous active-high reset.
REQ-005 flush_in  input  1  discard all buffered entries (branch/jump redirect).
REQ-006 fetch_valid_in  input  1  fetch stage presents an instruction.
REQ-007 fetch_ins_in  input  XLEN  fetched instruction word.
REQ-008 fetch_pc_in  input  XLEN  PC of the fetched instruction.
REQ-009 fetch_ready_out  output  1  buffer can accept an instruction this cycle.
REQ-010 dec_ready_in  input  1  decode stage consumes the head entry this cycle.
REQ-011 dec_valid_out  output  1  head entry is valid.
REQ-012 dec_pc_out  output  XLEN  PC of the head entry.
REQ-013 opcode_out  output  5  head instruction bits [6:2].
REQ-014 funct3_out  output  3  head instruction bits [14:12].
REQ-015 funct7_out  output  7  head instruction bits [31:25].
REQ-016 rs1_out / rs2_out / rd_out  output  5 each  head instruction bits [19:15] / [24:20] / [11:7].
REQ-017 illegal_out  output  1  head instruction bits [1:0] != 2'b11 (non-32-bit encoding).
REQ-018 count_out  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-019 Push SHALL occur on a rising edge when fetch_valid_in=1 and fetch_ready_out=1; the entry stores fetch_ins_in and fetch_pc_in.
REQ-020 Pop SHALL occur on a rising edge when dec_valid_out=1 and dec_ready_in=1; the head advances to the next-oldest entry.
REQ-021 fetch_ready_out SHALL be (count < DEPTH), driven from registered state only, with no combinational path from dec_ready_in.
REQ-022 dec_valid_out SHALL be (count != 0), driven from registered state only.
REQ-023 Entries SHALL leave in push order (FIFO); read/write pointers SHALL wrap modulo DEPTH.
REQ-024 Latency SHALL be one cycle: an entry pushed at edge N appears on the dec_* outputs after edge N.
REQ-025 Simultaneous push and pop (0 < count < DEPTH) SHALL leave count unchanged and preserve order.
REQ-026 Full: fetch_ready_out=0; fetch_valid_in is ignored, even when a pop occurs in the same cycle.
REQ-027 Empty: dec_valid_out=0; dec_ready_in is ignored; a push in the same cycle makes the entry visible next cycle (no bypass).
REQ-028 Output gating: when count=0, dec_pc_out, opcode_out, funct3_out, funct7_out, rs1_out, rs2_out, rd_out and illegal_out SHALL all be 0.
REQ-029 Field extraction SHALL be combinational from the head entry; no other decoding is performed.
REQ-030 Flush: when flush_in=1 at an edge, count and both pointers become 0, and any push or pop in that cycle is discarded.
REQ-031 Priority SHALL be reset > flush > push/pop.
REQ-032 count_out SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-033 When reset_in=1 at an edge, count, the read pointer and the write pointer SHALL become 0, giving fetch_ready_out=1, dec_valid_out=0, count_out=0 and all dec_* fields 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries, including any push or pop in the same cycle.
REQ-035 Entry storage need not be cleared on reset; REQ-028 guarantees zero outputs.

Verification
REQ-036 Reset, then push 0x00A28293 at PC 0x100 with dec_ready_in=0 -> next cycle: dec_valid_out=1, opcode_out=5'b00100, rd_out=5, rs1_out=5, funct3_out=0, funct7_out=0, dec_pc_out=0x100, count_out=1.
REQ-037 Push 3 instructions with dec_ready_in=0 (DEPTH=2) -> the first two are accepted, fetch_ready_out=0 after the second, and the third stays held upstream; then dec_ready_in=1 -> the instructions pop in order at PCs 0x100, 0x104.
REQ-038 Streaming with fetch_valid_in=1 and dec_ready_in=1 for 10 cycles -> count_out stays at 1 after the first push, and the 10 PCs are output in order with no gaps.
REQ-039 count=2 with flush_in=1 and fetch_valid_in=1 in the same cycle -> next cycle: count_out=0, dec_valid_out=0, and the pushed entry is lost.
REQ-040 Push 0x00000013 then 0x00000000 -> illegal_out=0 for the first entry and 1 for the second; reset_in with count=1 -> next cycle count_out=0 and all outputs 0.
